hazard_unit_mc: RTL and testbench

- Parametrised successor of the pipeline hazard detection unit.
- Adds support for a multi-cycle data memory: a MEM-stage wait FSM freezes the pipeline for MEM_LAT-1 extra cycles per access.
- Latches interrupts so they are never taken mid-access, and keeps a saturating stall-cycle performance counter.
- Sits beside the 5-stage datapath; all outputs drive pipeline-register enables and flushes.

---
 rtl/hazard_unit_mc.sv | 185 ++++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_mc
// Purpose  : Pipeline hazard detection for the 5-stage core with a
//            multi-cycle data memory. A MEM-stage wait FSM freezes the
//            pipeline while an access completes. Interrupts are latched and
//            deferred until the access finishes. A saturating counter tracks
//            stall and freeze cycles.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_mc #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic              RegWrite_EX,
    input  logic              RegWrite_MEM,
    input  logic              MemRead_EX,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_ID,
    input  logic              MemWrite_MEM,
    input  logic              branch_result,
    input  logic              IsBranch_ID,
    input  logic              IsJAL_ID,
    input  logic              IsJALR_ID,
    input  logic              interrupt_req,
    input  logic              mret_taken,
    output logic              stall,
    output logic              freeze,
    output logic              flush_IFID,
    output logic              flush_IDEX,
    output logic              flush_EXMEM,
    output logic              flush_MEMWB,
    output logic              branch_taken,
    output logic              interrupt_taken,
    output logic              irq_pending,
    output logic              mem_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    // Wait counter only has to hold MEM_LAT-2; keep at least one bit.
    localparam int   c_CNT_W       = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam int   c_CNT_INIT    = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic c_MULTI_CYCLE = (MEM_LAT > 1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic                irq_pending_q, irq_pending_d;
    logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic w_load_use, w_br_load, w_jalr_load, w_hazard;
    logic w_idle, w_wait, w_irq_any, w_take_irq, w_mret;
    logic w_mem_start, w_freeze, w_branch;

    // A younger instruction depends on an older one that writes a non-zero register.
    function automatic logic dep(input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] rs,
                                 input logic              we);
        return we && (rd != '0) && (rd == rs);
    endfunction

    assign w_load_use  = MemRead_EX && (dep(rd_EX, rs1_ID, RegWrite_EX) ||
                         (dep(rd_EX, rs2_ID, RegWrite_EX) && !MemWrite_ID));
    assign w_br_load   = IsBranch_ID &&
                         ((MemRead_EX  && (dep(rd_EX,  rs1_ID, RegWrite_EX)  ||
                                           dep(rd_EX,  rs2_ID, RegWrite_EX)))  ||
                          (MemRead_MEM && (dep(rd_MEM, rs1_ID, RegWrite_MEM) ||
                                           dep(rd_MEM, rs2_ID, RegWrite_MEM))));
    assign w_jalr_load = IsJALR_ID && MemRead_EX && dep(rd_EX, rs1_ID, RegWrite_EX);
    assign w_hazard    = w_load_use || w_br_load || w_jalr_load;

    assign w_idle      = (state_q == ST_IDLE);
    assign w_wait      = (state_q == ST_MEM_WAIT);
    assign w_irq_any   = interrupt_req || irq_pending_q;
    // Interrupts are only taken between accesses; they win over a new access and MRET.
    assign w_take_irq  = w_idle && w_irq_any;
    // MRET during a wait sees a bubble in WB, so it only acts from IDLE.
    assign w_mret      = w_idle && mret_taken && !w_take_irq;
    assign w_mem_start = c_MULTI_CYCLE && w_idle && (MemRead_MEM || MemWrite_MEM) &&
                         !w_irq_any && !mret_taken;
    // The last wait cycle (cnt==0) releases the pipeline.
    assign w_freeze    = w_mem_start || (w_wait && (cnt_q != '0));
    assign w_branch    = (IsBranch_ID && !w_br_load && branch_result) || IsJAL_ID ||
                         (IsJALR_ID && !w_jalr_load);

    // Priority decode of pipeline controls: freeze, interrupt, mret, normal hazards.
    always_comb begin
        stall           = 1'b0;
        freeze          = 1'b0;
        flush_IFID      = 1'b0;
        flush_IDEX      = 1'b0;
        flush_EXMEM     = 1'b0;
        flush_MEMWB     = 1'b0;
        branch_taken    = 1'b0;
        interrupt_taken = 1'b0;
        if (!rst) begin
            if (w_freeze) begin
                freeze      = 1'b1;
                stall       = 1'b1;
                flush_MEMWB = 1'b1;
            end else if (w_take_irq) begin
                interrupt_taken = 1'b1;
                flush_IFID      = 1'b1;
                flush_IDEX      = 1'b1;
                flush_EXMEM     = 1'b1;
                flush_MEMWB     = 1'b1;
            end else if (w_mret) begin
                flush_IFID  = 1'b1;
                flush_IDEX  = 1'b1;
                flush_EXMEM = 1'b1;
            end else begin
                branch_taken = w_branch;
                flush_IFID   = w_branch;
                if (w_hazard) begin
                    stall      = 1'b1;
                    flush_IDEX = 1'b1;
                end
            end
        end
    end

    // Next-state for the wait FSM, interrupt latch and stall counter.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        irq_pending_d  = irq_pending_q;
        stall_cycles_d = stall_cycles_q;
        case (state_q)
            ST_IDLE: begin
                if (w_mem_start) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = c_CNT_W'(c_CNT_INIT);
                end
            end
            ST_MEM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (interrupt_taken) begin
            irq_pending_d = 1'b0;
        end else if (interrupt_req) begin
            irq_pending_d = 1'b1;
        end
        if ((stall || freeze) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    // State registers; reset aborts any access in flight and drops the latched interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            irq_pending_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            irq_pending_q  <= irq_pending_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_busy     = (state_q == ST_MEM_WAIT);
    assign irq_pending  = irq_pending_q;
    assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit_mc
// Purpose  : Self-checking bench for hazard_unit_mc. Three instances share
//            stimulus: u0 (MEM_LAT=1), u1 (MEM_LAT=3), u2 (MEM_LAT=1, PERF_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_mc;

    // Flag vector order: {stall,freeze,fIFID,fIDEX,fEXMEM,fMEMWB,br,irq,pend,busy}
    localparam logic [9:0] c_S  = 10'h200;
    localparam logic [9:0] c_FZ = 10'h100;
    localparam logic [9:0] c_FI = 10'h080;
    localparam logic [9:0] c_FD = 10'h040;
    localparam logic [9:0] c_FE = 10'h020;
    localparam logic [9:0] c_FW = 10'h010;
    localparam logic [9:0] c_BT = 10'h008;
    localparam logic [9:0] c_IT = 10'h004;
    localparam logic [9:0] c_IP = 10'h002;
    localparam logic [9:0] c_MB = 10'h001;
    localparam logic [9:0] c_FRZ  = c_S | c_FZ | c_FW;
    localparam logic [9:0] c_TRAP = c_IT | c_FI | c_FD | c_FE | c_FW;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_ID, rs2_ID, rd_EX, rd_MEM;
    logic RegWrite_EX, RegWrite_MEM, MemRead_EX, MemRead_MEM, MemWrite_ID, MemWrite_MEM;
    logic branch_result, IsBranch_ID, IsJAL_ID, IsJALR_ID, interrupt_req, mret_taken;

    logic o_stall [3], o_freeze [3], o_fifid [3], o_fidex [3], o_fexmem [3], o_fmemwb [3];
    logic o_bt [3], o_it [3], o_ip [3], o_mb [3];
    logic [31:0] sc0, sc1;
    logic [3:0]  sc2;

    typedef struct {
        int          inst;
        string       tag;
        logic [9:0]  flags;
        bit          use_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .MEM_LAT(1), .PERF_W(32)) u0 (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EX(rd_EX), .rd_MEM(rd_MEM),
        .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .MemRead_EX(MemRead_EX),
        .MemRead_MEM(MemRead_MEM), .MemWrite_ID(MemWrite_ID), .MemWrite_MEM(MemWrite_MEM),
        .branch_result(branch_result), .IsBranch_ID(IsBranch_ID), .IsJAL_ID(IsJAL_ID),
        .IsJALR_ID(IsJALR_ID), .interrupt_req(interrupt_req), .mret_taken(mret_taken),
        .stall(o_stall[0]), .freeze(o_freeze[0]), .flush_IFID(o_fifid[0]), .flush_IDEX(o_fidex[0]),
        .flush_EXMEM(o_fexmem[0]), .flush_MEMWB(o_fmemwb[0]), .branch_taken(o_bt[0]),
        .interrupt_taken(o_it[0]), .irq_pending(o_ip[0]), .mem_busy(o_mb[0]), .stall_cycles(sc0));

    hazard_unit_mc #(.REG_AW(5), .MEM_LAT(3), .PERF_W(32)) u1 (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EX(rd_EX), .rd_MEM(rd_MEM),
        .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .MemRead_EX(MemRead_EX),
        .MemRead_MEM(MemRead_MEM), .MemWrite_ID(MemWrite_ID), .MemWrite_MEM(MemWrite_MEM),
        .branch_result(branch_result), .IsBranch_ID(IsBranch_ID), .IsJAL_ID(IsJAL_ID),
        .IsJALR_ID(IsJALR_ID), .interrupt_req(interrupt_req), .mret_taken(mret_taken),
        .stall(o_stall[1]), .freeze(o_freeze[1]), .flush_IFID(o_fifid[1]), .flush_IDEX(o_fidex[1]),
        .flush_EXMEM(o_fexmem[1]), .flush_MEMWB(o_fmemwb[1]), .branch_taken(o_bt[1]),
        .interrupt_taken(o_it[1]), .irq_pending(o_ip[1]), .mem_busy(o_mb[1]), .stall_cycles(sc1));

    hazard_unit_mc #(.REG_AW(5), .MEM_LAT(1), .PERF_W(4)) u2 (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EX(rd_EX), .rd_MEM(rd_MEM),
        .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .MemRead_EX(MemRead_EX),
        .MemRead_MEM(MemRead_MEM), .MemWrite_ID(MemWrite_ID), .MemWrite_MEM(MemWrite_MEM),
        .branch_result(branch_result), .IsBranch_ID(IsBranch_ID), .IsJAL_ID(IsJAL_ID),
        .IsJALR_ID(IsJALR_ID), .interrupt_req(interrupt_req), .mret_taken(mret_taken),
        .stall(o_stall[2]), .freeze(o_freeze[2]), .flush_IFID(o_fifid[2]), .flush_IDEX(o_fidex[2]),
        .flush_EXMEM(o_fexmem[2]), .flush_MEMWB(o_fmemwb[2]), .branch_taken(o_bt[2]),
        .interrupt_taken(o_it[2]), .irq_pending(o_ip[2]), .mem_busy(o_mb[2]), .stall_cycles(sc2));

    function automatic logic [9:0] flags_of(input int i);
        return {o_stall[i], o_freeze[i], o_fifid[i], o_fidex[i], o_fexmem[i], o_fmemwb[i],
                o_bt[i], o_it[i], o_ip[i], o_mb[i]};
    endfunction

    function automatic logic [31:0] cnt_of(input int i);
        if (i == 0) return sc0;
        if (i == 1) return sc1;
        return {28'd0, sc2};
    endfunction

    function automatic void push(input int inst, input string tag, input logic [9:0] flags,
                                 input bit use_cnt, input logic [31:0] cnt);
        exp_t x;
        x.inst = inst; x.tag = tag; x.flags = flags; x.use_cnt = use_cnt; x.cnt = cnt;
        exp_q.push_back(x);
    endfunction

    task automatic clear_inputs();
        rs1_ID = '0; rs2_ID = '0; rd_EX = '0; rd_MEM = '0;
        RegWrite_EX = 0; RegWrite_MEM = 0; MemRead_EX = 0; MemRead_MEM = 0;
        MemWrite_ID = 0; MemWrite_MEM = 0; branch_result = 0; IsBranch_ID = 0;
        IsJAL_ID = 0; IsJALR_ID = 0; interrupt_req = 0; mret_taken = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic load_in_ex(input logic [4:0] rd);
        MemRead_EX = 1; RegWrite_EX = 1; rd_EX = rd;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                rst = 1; IsJAL_ID = 1; interrupt_req = 1; MemRead_MEM = 1;
                load_in_ex(5'd1); rs1_ID = 5'd1;
            end else begin
                clear_inputs(); rst = 0;
            end
            for (int k = 0; k < 3; k++) push(k, "reset", 10'h000, 1, 32'd0);
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin load_in_ex(5'd1); rs1_ID = 5'd1; MemRead_MEM = 1; RegWrite_MEM = 1;
                         rd_MEM = 5'd3; push(0, "load_use", c_S | c_FD, 0, 0); end
                1, 2: push(0, "load_use_nobusy", c_S | c_FD, 0, 0);
                3: begin rs1_ID = 5'd2; rs2_ID = 5'd1; MemWrite_ID = 1;
                         push(0, "store_rs2_no_stall", 10'h000, 0, 0); end
                4: begin MemWrite_ID = 0; push(0, "load_use_rs2", c_S | c_FD, 0, 0); end
                5: begin rd_EX = 5'd0; rs1_ID = 5'd0; rs2_ID = 5'd0;
                         push(0, "x0_no_dep", 10'h000, 1, 32'd4); end
                default: begin RegWrite_EX = 0; rd_EX = 5'd1; rs1_ID = 5'd1;
                         push(0, "no_we_no_dep", 10'h000, 1, 32'd4); end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin MemRead_MEM = 1; push(1, "wait_start", c_FRZ, 1, 32'd0);
                         push(0, "lat1_no_freeze", 10'h000, 0, 0); end
                1: push(1, "wait_cnt1", c_FRZ | c_MB, 1, 32'd1);
                2: push(1, "wait_last", c_MB, 1, 32'd2);
                default: begin MemRead_MEM = 0; push(1, "wait_done", 10'h000, 1, 32'd2); end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin MemRead_MEM = 1; push(1, "b2b_start1", c_FRZ, 0, 0); end
                1: push(1, "b2b_wait1", c_FRZ | c_MB, 0, 0);
                2: begin load_in_ex(5'd2); rs1_ID = 5'd2;
                         push(1, "b2b_last_hazard", c_MB | c_S | c_FD, 1, 32'd2); end
                3: begin clear_inputs(); MemWrite_MEM = 1; push(1, "b2b_start2", c_FRZ, 1, 32'd3); end
                4: push(1, "b2b_wait2", c_FRZ | c_MB, 1, 32'd4);
                5: push(1, "b2b_last2", c_MB, 1, 32'd5);
                default: begin MemWrite_MEM = 0; push(1, "b2b_idle", 10'h000, 1, 32'd5); end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_irq_deferred();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin MemRead_MEM = 1; push(1, "irqd_start", c_FRZ, 0, 0); end
                1: begin interrupt_req = 1; push(1, "irqd_in_wait", c_FRZ | c_MB, 0, 0); end
                2: begin interrupt_req = 0; push(1, "irqd_pending", c_MB | c_IP, 0, 0); end
                3: begin MemRead_MEM = 0; push(1, "irqd_taken", c_TRAP | c_IP, 0, 0); end
                default: push(1, "irqd_cleared", 10'h000, 0, 0);
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_irq_blocks_start();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                interrupt_req = 1; MemWrite_MEM = 1;
                push(1, "irq_over_start", c_TRAP, 0, 0);
                push(0, "irq_lat1", c_TRAP, 0, 0);
            end else begin
                interrupt_req = 0; MemWrite_MEM = 0;
                push(1, "irq_no_wait", 10'h000, 1, 32'd0);
                push(0, "irq_lat1_clear", 10'h000, 0, 0);
            end
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mret();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin mret_taken = 1; MemRead_MEM = 1;
                         push(1, "mret_idle", c_FI | c_FD | c_FE, 0, 0); end
                1: begin mret_taken = 0; MemRead_MEM = 0; push(1, "mret_no_wait", 10'h000, 0, 0); end
                2: begin MemRead_MEM = 1; push(1, "mret_start", c_FRZ, 0, 0); end
                3: begin mret_taken = 1; push(1, "mret_in_wait", c_FRZ | c_MB, 0, 0); end
                4: push(1, "mret_last_ignored", c_MB, 0, 0);
                default: begin mret_taken = 0; MemRead_MEM = 0; push(1, "mret_idle2", 10'h000, 0, 0); end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin IsBranch_ID = 1; rs1_ID = 5'd5; MemRead_MEM = 1; RegWrite_MEM = 1;
                         rd_MEM = 5'd5; branch_result = 1; push(0, "br_load_mem", c_S | c_FD, 0, 0); end
                1: begin MemRead_MEM = 0; RegWrite_MEM = 0; push(0, "br_taken", c_BT | c_FI, 0, 0); end
                2: begin branch_result = 0; push(0, "br_not_taken", 10'h000, 0, 0); end
                3: begin IsBranch_ID = 0; IsJAL_ID = 1; push(0, "jal", c_BT | c_FI, 0, 0); end
                4: begin IsJAL_ID = 0; IsJALR_ID = 1; load_in_ex(5'd5);
                         push(0, "jalr_load", c_S | c_FD, 0, 0); end
                5: begin MemRead_EX = 0; push(0, "jalr_go", c_BT | c_FI, 0, 0); end
                6: begin IsJALR_ID = 0; IsBranch_ID = 1; branch_result = 1; rs1_ID = 5'd0;
                         rs2_ID = 5'd7; load_in_ex(5'd7); push(0, "br_load_ex_rs2", c_S | c_FD, 0, 0); end
                default: begin clear_inputs(); push(0, "br_idle", 10'h000, 0, 0); end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 23; i++) begin
            if (i < 20) begin
                load_in_ex(5'd4); rs1_ID = 5'd4;
                push(2, "sat_count", c_S | c_FD, 1, (i < 15) ? i : 15);
            end else if (i == 20) begin
                clear_inputs(); push(2, "sat_hold", 10'h000, 1, 32'd15);
            end else if (i == 21) begin
                load_in_ex(5'd4); rs1_ID = 5'd4;
                #2 rst = 1;
                push(2, "sat_async_rst", 10'h000, 1, 32'd0);
            end else begin
                rst = 0; clear_inputs(); push(2, "sat_after_rst", 10'h000, 1, 32'd0);
            end
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin MemRead_MEM = 1; push(1, "rmw_start", c_FRZ, 0, 0); end
                1: begin interrupt_req = 1; push(1, "rmw_irq", c_FRZ | c_MB, 0, 0); end
                2: begin interrupt_req = 0; #2 rst = 1;
                         push(1, "rmw_async_rst", 10'h000, 1, 32'd0); end
                default: begin rst = 0; MemRead_MEM = 0;
                         push(1, "rmw_no_irq", 10'h000, 1, 32'd0); end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flags_of(e.inst) !== e.flags || (e.use_cnt && cnt_of(e.inst) !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s c%0d u%0d: flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                             e.tag, i, e.inst, flags_of(e.inst), cnt_of(e.inst), e.flags, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_back_to_back();
        test_irq_deferred();
        test_irq_blocks_start();
        test_mret();
        test_branch();
        test_saturate();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
